// File: rtl/mash_mod_cfg.sv
// mash_mod_cfg: runtime-configurable MASH 1-1-..-1 delta-sigma modulator
// with programmable modulus, selectable order and optional LFSR LSB dither.
module mash_mod_cfg #(
    parameter int WIDTH_MODULUS = 16,
    parameter int MAX_ORDER     = 4,
    parameter int OUT_W         = MAX_ORDER + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [WIDTH_MODULUS-1:0]         frac_in,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [$clog2(MAX_ORDER+1)-1:0]   cfg_order,
    input  logic [WIDTH_MODULUS-1:0]         cfg_modulus,
    input  logic                             cfg_dither,
    output logic signed [OUT_W-1:0]          data_out,
    output logic                             out_valid,
    output logic                             clamp_err
);
    localparam int W  = WIDTH_MODULUS;
    localparam int OW = $clog2(MAX_ORDER + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [OW-1:0] order, order_c;
    logic [W-1:0] modulus, modulus_c;
    logic dither;
    logic [14:0] lfsr;
    logic [W-1:0] acc [MAX_ORDER];
    logic [W-1:0] acc_nxt [MAX_ORDER];
    logic signed [OUT_W-1:0] hist [MAX_ORDER];
    logic signed [OUT_W-1:0] t [MAX_ORDER];
    logic [MAX_ORDER-1:0] carry;
    logic [W-1:0] f;
    logic [W:0] stage_in, sum, diff;
    logic clamp, accept, advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, RUN: begin
                cfg_ready = 1'b1;
                accept    = cfg_valid;
                if (cfg_valid) state_nxt = FLUSH;
                else           state_nxt = en ? RUN : IDLE;
            end
            FLUSH:   state_nxt = en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A configuration accept on an enabled edge takes priority over a sample.
    assign advance = en & ~accept;

    always_comb begin
        if (cfg_order == '0)
            order_c = OW'(1);
        else if (int'(cfg_order) > MAX_ORDER)
            order_c = OW'(MAX_ORDER);
        else
            order_c = cfg_order;
        modulus_c = (cfg_modulus < W'(2)) ? W'(2) : cfg_modulus;
    end

    always_comb begin
        clamp    = frac_in >= modulus;
        f        = clamp ? modulus - W'(1) : frac_in;
        stage_in = {1'b0, f} + (W+1)'(dither & lfsr[0]);
        sum      = '0;
        diff     = '0;
        carry    = '0;
        for (int k = 0; k < MAX_ORDER; k++) begin
            acc_nxt[k] = '0;
            if (k < int'(order)) begin
                sum        = {1'b0, acc[k]} + stage_in;
                diff       = sum - {1'b0, modulus};
                carry[k]   = sum >= {1'b0, modulus};
                acc_nxt[k] = carry[k] ? diff[W-1:0] : sum[W-1:0];
                stage_in   = {1'b0, acc_nxt[k]};
            end
        end
        // Nested differentiators: t_k = c_k + (1 - z^-1) t_{k+1}.
        t[MAX_ORDER-1] = OUT_W'(carry[MAX_ORDER-1]);
        for (int k = MAX_ORDER - 2; k >= 0; k--)
            t[k] = OUT_W'(carry[k]) + t[k+1] - hist[k+1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order     <= OW'(1);
            modulus   <= '1;
            dither    <= 1'b0;
            lfsr      <= 15'h0001;
            clamp_err <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < MAX_ORDER; k++) begin
                acc[k]  <= '0;
                hist[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (en)
                lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            if (accept) begin
                order   <= order_c;
                modulus <= modulus_c;
                dither  <= cfg_dither;
                for (int k = 0; k < MAX_ORDER; k++) begin
                    acc[k]  <= '0;
                    hist[k] <= '0;
                end
            end else if (advance) begin
                out_valid <= 1'b1;
                clamp_err <= clamp_err | clamp;
                for (int k = 0; k < MAX_ORDER; k++) begin
                    acc[k]  <= acc_nxt[k];
                    hist[k] <= t[k];
                end
            end
        end
    end

    // The first-stage history register is exactly the last output sample.
    assign data_out = hist[0];

endmodule

// File: doc/mash_mod_cfg.md
Name: mash_mod_cfg

Overview:
Runtime-configurable MASH 1-1-…-1 delta-sigma modulator for the fractional-N divider. It generalises the fixed-order, power-of-two-modulus modulator in three ways:
- active order selectable at run time, 1..MAX_ORDER;
- arbitrary programmable modulus;
- optional LFSR LSB dither.
Configuration is applied through a valid/ready handshake that flushes modulator state. The signed output drives the divider-ratio adder.

Parameters:
WIDTH_MODULUS, 16, width of modulus, fractional word and accumulators
MAX_ORDER, 4, maximum number of cascaded stages (>=1)
OUT_W, MAX_ORDER+1, signed output width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  modulator advance enable
frac_in  in  WIDTH_MODULUS  fractional numerator, sampled every enabled cycle
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration accept
cfg_order  in  $clog2(MAX_ORDER+1)  active order, 1..MAX_ORDER
cfg_modulus  in  WIDTH_MODULUS  modulus M, >=2
cfg_dither  in  1  dither enable
data_out  out  OUT_W  signed divider offset
out_valid  out  1  data_out valid
clamp_err  out  1  sticky: frac_in >= M was seen

Behaviour:
- Reset (async, rst high):
  - accumulators, difference history, data_out and out_valid = 0; clamp_err = 0;
  - order = 1, M = 2^WIDTH_MODULUS-1, dither off, LFSR = 15'h0001;
  - state = IDLE.
- States:
  - IDLE: en = 0.
  - RUN: en = 1.
  - FLUSH: exactly one cycle after a configuration is accepted, then RUN if en else IDLE.
  - cfg_ready = 1 in IDLE and RUN, 0 in FLUSH.
- Configuration handshake:
  - accepted on an edge with cfg_valid & cfg_ready;
  - cfg_order 0 is stored as 1; values > MAX_ORDER are stored as MAX_ORDER;
  - cfg_modulus < 2 is stored as 2.
- FLUSH: clears all accumulators and history, forces out_valid = 0 and data_out = 0, and leaves the LFSR running.
- Effective input: f = min(frac_in, M-1). If frac_in >= M, clamp_err is set; it clears only on rst.
- Stage arithmetic (per enabled RUN cycle, WIDTH_MODULUS+1-bit compare):
  - stage k sum s_k = acc_k + in_k;
  - if s_k >= M: c_k = 1 and acc_k <= s_k-M; else c_k = 0 and acc_k <= s_k.
- Stage inputs:
  - in_1 = f + d, where d = LFSR bit 0 if dither is on, else 0;
  - in_k = new residue of stage k-1 in the same cycle (combinational ripple, no inter-stage delay).
- Stages k > order are held at 0 with c_k = 0.
- Noise cancellation: y[n] = sum over k of (1-z^-1)^(k-1) c_k[n], with sign-extended difference registers. History is zero after reset or FLUSH.
- Output timing:
  - data_out <= y and out_valid <= 1 on the same edge that updates the accumulators;
  - latency is 1 edge from frac_in sampling to data_out.
- Output range for order L: [-(2^(L-1)-1), 2^(L-1)].
- With en = 0 all state holds: data_out holds and out_valid = 0. The LFSR advances only on enabled cycles.
- LFSR polynomial: x^15+x^14+1, Fibonacci, shifting left.
- Simultaneous en and cfg accept: the configuration wins; that cycle is FLUSH and no sample is produced.
- Changes to frac_in take effect on the next enabled edge without flushing.
- rst asserted mid-operation returns everything to the reset values immediately.

Test Plan:
- Order 1, M=16, frac=4, dither off, en=1 -> data_out sequence 0,0,0,1 repeating; out_valid rises 1 edge after en.
- Order 2, M=16, frac=8 -> data_out 0,1,1,0,0,1,1,0…; no clamp_err.
- Order 3, M=1000, frac=333, 3000 enabled cycles -> sum of data_out = 999 ±4; every sample in [-3,4].
- Reconfigure mid-run from order 2 to order 4 with M=10:
  - cfg_ready=0 and out_valid=0 for exactly one cycle;
  - the sequence then restarts from zero state, with samples in [-7,8].
- frac=20 with M=16 -> behaves exactly as frac=15; clamp_err=1 and stays set until rst.
- Pulse rst during RUN -> data_out=0, out_valid=0, state IDLE and cfg defaults restored asynchronously; with dither on, the LFSR sequence restarts from 0x0001.
